// File: rtl/yapay_zeka_denetleyici.sv
// yapay_zeka_denetleyici: sequencer for the AI unit's data (veri) and weight (agirlik) banks.
//   Loads 1- or 2-word commands into either bank, runs an N-entry signed dot product
//   over both banks and returns the 32-bit result on a valid/ready handshake.
//   Ports:
//     clk_i, rst_i                      clock, synchronous active-high reset
//     buyruk_gecerli_i/buyruk_hazir_o   command handshake
//     buyruk_tip_i                      0 VERI_YUKLE, 1 AGIRLIK_YUKLE, 2 CALISTIR, 3 SIFIRLA
//     deger1_i, deger2_i, ikinci_gecerli_i  load words ([3:0] of deger1_i = N-1 for CALISTIR)
//     yaz1/yaz2_deger_o, *_yaz*_en_o    bank write words and enables
//     *_oku_en_o, *_deger_i             bank read-pointer advance and current read word
//     obek_sifirla_o                    clear to both banks
//     sonuc_o/sonuc_gecerli_o/sonuc_hazir_i  result handshake
//     hata_o                            sticky error flag
//   Macro YZ_DOYURMA_EN: saturating 64-bit-product accumulation instead of 32-bit wrap.
module yapay_zeka_denetleyici #(
    parameter int DERINLIK = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        buyruk_gecerli_i,
    output logic        buyruk_hazir_o,
    input  logic [1:0]  buyruk_tip_i,
    input  logic [31:0] deger1_i,
    input  logic [31:0] deger2_i,
    input  logic        ikinci_gecerli_i,
    output logic [31:0] yaz1_deger_o,
    output logic [31:0] yaz2_deger_o,
    output logic        veri_yaz1_en_o,
    output logic        veri_yaz2_en_o,
    output logic        agirlik_yaz1_en_o,
    output logic        agirlik_yaz2_en_o,
    output logic        veri_oku_en_o,
    output logic        agirlik_oku_en_o,
    input  logic [31:0] veri_deger_i,
    input  logic [31:0] agirlik_deger_i,
    output logic        obek_sifirla_o,
    output logic [31:0] sonuc_o,
    output logic        sonuc_gecerli_o,
    input  logic        sonuc_hazir_i,
    output logic        hata_o
);
    localparam int AW = $clog2(DERINLIK);
    localparam int SW = $clog2(DERINLIK + 1);
    localparam logic [SW-1:0] DOLU = SW'(DERINLIK);

    typedef enum logic [1:0] {BOSTA, HESAPLA, SONUC, TEMIZLE} durum_t;
    durum_t durum, sonraki;

    logic [SW-1:0] veri_dolu, agirlik_dolu, sayac, n_kayit, n_yeni;
    logic [31:0]   acc, sonraki_acc;
    logic          hata;
    logic          kabul, veri_yukle, agirlik_yukle, calistir, sifirla;
    logic          yetersiz, veri_tasma, agirlik_tasma, son_adim;

    assign kabul         = buyruk_gecerli_i && durum == BOSTA;
    assign veri_yukle    = kabul && buyruk_tip_i == 2'd0;
    assign agirlik_yukle = kabul && buyruk_tip_i == 2'd1;
    assign calistir      = kabul && buyruk_tip_i == 2'd2;
    assign sifirla       = kabul && buyruk_tip_i == 2'd3;
    assign n_yeni        = SW'(deger1_i[AW-1:0]) + SW'(1);
    assign yetersiz      = n_yeni > veri_dolu || n_yeni > agirlik_dolu;
    assign son_adim      = durum == HESAPLA && sayac == SW'(1);

    // A full bank takes nothing; one slot left takes only the first word.
    assign veri_yaz1_en_o    = veri_yukle && veri_dolu != DOLU;
    assign veri_yaz2_en_o    = veri_yukle && ikinci_gecerli_i && veri_dolu < DOLU - SW'(1);
    assign agirlik_yaz1_en_o = agirlik_yukle && agirlik_dolu != DOLU;
    assign agirlik_yaz2_en_o = agirlik_yukle && ikinci_gecerli_i && agirlik_dolu < DOLU - SW'(1);
    assign veri_tasma        = veri_yukle && (veri_dolu == DOLU || (ikinci_gecerli_i && veri_dolu == DOLU - SW'(1)));
    assign agirlik_tasma     = agirlik_yukle && (agirlik_dolu == DOLU || (ikinci_gecerli_i && agirlik_dolu == DOLU - SW'(1)));

    assign yaz1_deger_o     = (veri_yukle || agirlik_yukle) ? deger1_i : '0;
    assign yaz2_deger_o     = (veri_yukle || agirlik_yukle) ? deger2_i : '0;
    assign buyruk_hazir_o   = durum == BOSTA;
    assign veri_oku_en_o    = durum == HESAPLA;
    assign agirlik_oku_en_o = durum == HESAPLA;
    assign obek_sifirla_o   = durum == TEMIZLE;
    assign sonuc_gecerli_o  = durum == SONUC;
    assign sonuc_o          = durum == SONUC ? acc : '0;
    assign hata_o           = hata;

`ifdef YZ_DOYURMA_EN
    logic               doymus, doymus_yeni;
    logic signed [63:0] carpim, genis;
    always_comb begin
        carpim      = $signed({{32{veri_deger_i[31]}}, veri_deger_i}) * $signed({{32{agirlik_deger_i[31]}}, agirlik_deger_i});
        genis       = $signed({{32{acc[31]}}, acc}) + carpim;
        doymus_yeni = doymus || genis > 64'sh0000_0000_7FFF_FFFF || genis < 64'shFFFF_FFFF_8000_0000;
        // Once clamped, the value is frozen until the next run.
        sonraki_acc = doymus ? acc :
                      genis > 64'sh0000_0000_7FFF_FFFF ? 32'h7FFF_FFFF :
                      genis < 64'shFFFF_FFFF_8000_0000 ? 32'h8000_0000 : genis[31:0];
    end
`else
    assign sonraki_acc = acc + 32'($signed(veri_deger_i) * $signed(agirlik_deger_i));
`endif

    always_comb begin
        sonraki = durum;
        case (durum)
            BOSTA:   sonraki = calistir ? (yetersiz ? SONUC : HESAPLA) : sifirla ? TEMIZLE : BOSTA;
            HESAPLA: sonraki = sayac == SW'(1) ? SONUC : HESAPLA;
            SONUC:   sonraki = sonuc_hazir_i ? BOSTA : SONUC;
            default: sonraki = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum        <= BOSTA;
            veri_dolu    <= '0;
            agirlik_dolu <= '0;
            sayac        <= '0;
            n_kayit      <= '0;
            acc          <= '0;
            hata         <= 1'b0;
`ifdef YZ_DOYURMA_EN
            doymus       <= 1'b0;
`endif
        end else begin
            durum <= sonraki;
            // Clearing already on SIFIRLA accept keeps hata_o low during the TEMIZLE pulse.
            if (sifirla || durum == TEMIZLE) begin
                veri_dolu    <= '0;
                agirlik_dolu <= '0;
                acc          <= '0;
                hata         <= 1'b0;
            end else begin
                veri_dolu    <= veri_dolu + SW'(veri_yaz1_en_o) + SW'(veri_yaz2_en_o) - (son_adim ? n_kayit : '0);
                agirlik_dolu <= agirlik_dolu + SW'(agirlik_yaz1_en_o) + SW'(agirlik_yaz2_en_o) - (son_adim ? n_kayit : '0);
                if (veri_tasma || agirlik_tasma || (calistir && yetersiz))
                    hata <= 1'b1;
                if (calistir) begin
                    acc     <= '0;
                    sayac   <= n_yeni;
                    n_kayit <= n_yeni;
`ifdef YZ_DOYURMA_EN
                    doymus  <= 1'b0;
`endif
                end else if (durum == HESAPLA) begin
                    acc     <= sonraki_acc;
                    sayac   <= sayac - SW'(1);
`ifdef YZ_DOYURMA_EN
                    doymus  <= doymus_yeni;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_yapay_zeka_denetleyici.sv
// tb_yapay_zeka_denetleyici: directed self-checking bench with a simple bank model.
module tb_yapay_zeka_denetleyici;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        buyruk_gecerli = 1'b0;
    logic        buyruk_hazir;
    logic [1:0]  buyruk_tip = 2'd0;
    logic [31:0] deger1 = '0, deger2 = '0;
    logic        ikinci_gecerli = 1'b0;
    logic [31:0] yaz1_deger, yaz2_deger;
    logic        veri_yaz1_en, veri_yaz2_en, agirlik_yaz1_en, agirlik_yaz2_en;
    logic        veri_oku_en, agirlik_oku_en;
    logic [31:0] veri_deger, agirlik_deger;
    logic        obek_sifirla;
    logic [31:0] sonuc;
    logic        sonuc_gecerli;
    logic        sonuc_hazir = 1'b0;
    logic        hata;

    int kontrol_sayisi = 0;
    int hata_sayisi = 0;

`ifdef YZ_DOYURMA_EN
    localparam logic [31:0] DOY_BEKLENEN = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] DOY_BEKLENEN = 32'h0;
`endif

    yapay_zeka_denetleyici dut (
        .clk_i(clk), .rst_i(rst),
        .buyruk_gecerli_i(buyruk_gecerli), .buyruk_hazir_o(buyruk_hazir),
        .buyruk_tip_i(buyruk_tip), .deger1_i(deger1), .deger2_i(deger2),
        .ikinci_gecerli_i(ikinci_gecerli),
        .yaz1_deger_o(yaz1_deger), .yaz2_deger_o(yaz2_deger),
        .veri_yaz1_en_o(veri_yaz1_en), .veri_yaz2_en_o(veri_yaz2_en),
        .agirlik_yaz1_en_o(agirlik_yaz1_en), .agirlik_yaz2_en_o(agirlik_yaz2_en),
        .veri_oku_en_o(veri_oku_en), .agirlik_oku_en_o(agirlik_oku_en),
        .veri_deger_i(veri_deger), .agirlik_deger_i(agirlik_deger),
        .obek_sifirla_o(obek_sifirla),
        .sonuc_o(sonuc), .sonuc_gecerli_o(sonuc_gecerli), .sonuc_hazir_i(sonuc_hazir),
        .hata_o(hata)
    );

    always #5 clk = ~clk;

    // Bank model: write pointer advances per word written, read pointer per oku_en.
    logic [31:0] veri_mem [16];
    logic [31:0] agirlik_mem [16];
    logic [3:0]  veri_wp = '0, veri_rp = '0, agirlik_wp = '0, agirlik_rp = '0;
    assign veri_deger    = veri_mem[veri_rp];
    assign agirlik_deger = agirlik_mem[agirlik_rp];

    initial for (int i = 0; i < 16; i++) begin
        veri_mem[i]    = '0;
        agirlik_mem[i] = '0;
    end

    always @(posedge clk) begin
        if (rst || obek_sifirla) begin
            veri_wp <= '0; veri_rp <= '0; agirlik_wp <= '0; agirlik_rp <= '0;
        end else begin
            if (veri_yaz1_en) veri_mem[veri_wp] <= yaz1_deger;
            if (veri_yaz2_en) veri_mem[veri_wp + 4'd1] <= yaz2_deger;
            if (agirlik_yaz1_en) agirlik_mem[agirlik_wp] <= yaz1_deger;
            if (agirlik_yaz2_en) agirlik_mem[agirlik_wp + 4'd1] <= yaz2_deger;
            veri_wp    <= veri_wp + 4'(veri_yaz1_en) + 4'(veri_yaz2_en);
            agirlik_wp <= agirlik_wp + 4'(agirlik_yaz1_en) + 4'(agirlik_yaz2_en);
            if (veri_oku_en) veri_rp <= veri_rp + 4'd1;
            if (agirlik_oku_en) agirlik_rp <= agirlik_rp + 4'd1;
        end
    end

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        kontrol_sayisi++;
        if (gozlenen !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic surec(input logic [1:0] tip, input logic [31:0] d1, input logic [31:0] d2, input logic ik);
        buyruk_gecerli = 1'b1;
        buyruk_tip     = tip;
        deger1         = d1;
        deger2         = d2;
        ikinci_gecerli = ik;
        #1;
    endtask

    task automatic adim();
        @(posedge clk);
        #1;
        buyruk_gecerli = 1'b0;
        ikinci_gecerli = 1'b0;
        #1;
    endtask

    task automatic bosta_cikislar(input string etiket);
        kontrol({etiket, "_hazir"}, 32'(buyruk_hazir), 32'd1);
        kontrol({etiket, "_gecerli"}, 32'(sonuc_gecerli), 32'd0);
        kontrol({etiket, "_sonuc"}, sonuc, 32'd0);
        kontrol({etiket, "_oku"}, 32'({veri_oku_en, agirlik_oku_en}), 32'd0);
        kontrol({etiket, "_obek"}, 32'(obek_sifirla), 32'd0);
        kontrol({etiket, "_hata"}, 32'(hata), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        bosta_cikislar("reset");

        // Dot product {1,2,3}.{4,5,6} = 32
        surec(2'd0, 32'd1, 32'd2, 1'b1);
        kontrol("t1_veri_en", 32'({veri_yaz1_en, veri_yaz2_en, agirlik_yaz1_en}), 32'b110);
        kontrol("t1_yaz1", yaz1_deger, 32'd1);
        kontrol("t1_yaz2", yaz2_deger, 32'd2);
        adim();
        surec(2'd0, 32'd3, 32'd0, 1'b0);
        kontrol("t1_tek_en", 32'({veri_yaz1_en, veri_yaz2_en}), 32'b10);
        adim();
        surec(2'd1, 32'd4, 32'd5, 1'b1);
        kontrol("t1_agirlik_en", 32'({agirlik_yaz1_en, agirlik_yaz2_en, veri_yaz1_en}), 32'b110);
        adim();
        surec(2'd1, 32'd6, 32'd0, 1'b0);
        adim();
        surec(2'd2, 32'd2, 32'd0, 1'b0);
        adim();
        for (int i = 0; i < 3; i++) begin
            kontrol("t1_hesapla_oku", 32'({veri_oku_en, agirlik_oku_en, buyruk_hazir, sonuc_gecerli}), 32'b1100);
            adim();
        end
        kontrol("t1_gecerli", 32'(sonuc_gecerli), 32'd1);
        kontrol("t1_sonuc", sonuc, 32'd32);
        sonuc_hazir = 1'b1;
        adim();
        sonuc_hazir = 1'b0;
        kontrol("t1_donus", 32'({buyruk_hazir, sonuc_gecerli}), 32'b10);

        // {-3,7}.{2,-1} = -13, held while the consumer stalls
        surec(2'd0, -32'sd3, 32'd7, 1'b1);
        adim();
        surec(2'd1, 32'd2, -32'sd1, 1'b1);
        adim();
        surec(2'd2, 32'd1, 32'd0, 1'b0);
        adim();
        adim();
        adim();
        for (int i = 0; i < 5; i++) begin
            kontrol("t2_bekle_gecerli", 32'({sonuc_gecerli, buyruk_hazir}), 32'b10);
            kontrol("t2_bekle_sonuc", sonuc, 32'hFFFF_FFF3);
            adim();
        end
        sonuc_hazir = 1'b1;
        #1;
        kontrol("t2_hazir_an", sonuc, 32'hFFFF_FFF3);
        adim();
        sonuc_hazir = 1'b0;
        kontrol("t2_donus", 32'({buyruk_hazir, sonuc_gecerli}), 32'b10);
        kontrol("t2_hata_yok", 32'(hata), 32'd0);

        // Overflow: 15 single loads then a 2-word load
        for (int i = 0; i < 15; i++) begin
            surec(2'd0, 32'(i + 10), 32'd0, 1'b0);
            adim();
        end
        kontrol("t3_hata_once", 32'(hata), 32'd0);
        surec(2'd0, 32'd99, 32'd98, 1'b1);
        kontrol("t3_taşma_en", 32'({veri_yaz1_en, veri_yaz2_en}), 32'b10);
        adim();
        kontrol("t3_hata", 32'(hata), 32'd1);
        surec(2'd0, 32'd5, 32'd0, 1'b0);
        kontrol("t3_dolu_en", 32'({veri_yaz1_en, veri_yaz2_en}), 32'b00);
        adim();
        surec(2'd2, 32'd15, 32'd0, 1'b0);
        adim();
        kontrol("t3_calistir_oku", 32'({veri_oku_en, agirlik_oku_en}), 32'd0);
        kontrol("t3_gecerli", 32'(sonuc_gecerli), 32'd1);
        kontrol("t3_sonuc", sonuc, 32'd0);
        sonuc_hazir = 1'b1;
        adim();
        sonuc_hazir = 1'b0;
        kontrol("t3_hata_yapiskan", 32'(hata), 32'd1);

        // SIFIRLA after the error
        surec(2'd3, 32'd0, 32'd0, 1'b0);
        kontrol("t4_kabul", 32'(buyruk_hazir), 32'd1);
        adim();
        kontrol("t4_temizle", 32'({obek_sifirla, hata, buyruk_hazir}), 32'b100);
        adim();
        kontrol("t4_sonra", 32'({obek_sifirla, hata, buyruk_hazir}), 32'b001);

        // 0x40000000*4 twice: wraps to 0 or saturates
        surec(2'd0, 32'h4000_0000, 32'h4000_0000, 1'b1);
        adim();
        surec(2'd1, 32'd4, 32'd4, 1'b1);
        adim();
        surec(2'd2, 32'd1, 32'd0, 1'b0);
        adim();
        adim();
        adim();
        kontrol("t5_gecerli", 32'(sonuc_gecerli), 32'd1);
        kontrol("t5_sonuc", sonuc, DOY_BEKLENEN);
        sonuc_hazir = 1'b1;
        adim();
        sonuc_hazir = 1'b0;

        // Reset in the 2nd cycle of an N=8 run
        for (int i = 0; i < 4; i++) begin
            surec(2'd0, 32'(2 * i + 1), 32'(2 * i + 2), 1'b1);
            adim();
            surec(2'd1, 32'd3, 32'd3, 1'b1);
            adim();
        end
        surec(2'd2, 32'd7, 32'd0, 1'b0);
        adim();
        kontrol("t6_hesapla1", 32'(veri_oku_en), 32'd1);
        adim();
        kontrol("t6_hesapla2", 32'(veri_oku_en), 32'd1);
        rst = 1'b1;
        adim();
        rst = 1'b0;
        #1;
        bosta_cikislar("t6_reset");
        kontrol("t6_yaz", 32'({veri_yaz1_en, veri_yaz2_en, agirlik_yaz1_en, agirlik_yaz2_en}), 32'd0);
        kontrol("t6_yaz_deger", yaz1_deger | yaz2_deger, 32'd0);
        for (int i = 0; i < 10; i++) begin
            kontrol("t6_sonuc_yok", 32'(sonuc_gecerli), 32'd0);
            adim();
        end

        $display("Result: errors=%0d of %0d checks", hata_sayisi, kontrol_sayisi);
        $finish;
    end
endmodule

// File: doc/yapay_zeka_denetleyici.md
Name: yapay_zeka_denetleyici

Overview:
- Sequencer for the AI unit's two 16-entry register banks: a data bank (veri) and a weight bank (agirlik).
- Accepts X-instruction commands over a valid/ready handshake and routes 1- or 2-word loads to the selected bank.
- On a run command, streams N entry pairs out of both banks through a signed multiply-accumulate and returns the 32-bit dot product on a result handshake.
- Sits between the X-instruction decode stage and the register banks inside the yapay_zeka_birimi.

Parameters:
- DERINLIK, 16, entries per bank; also the maximum run length.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset; synchronous, active-high
- buyruk_gecerli_i  input  1  command valid
- buyruk_hazir_o  output  1  command ready
- buyruk_tip_i  input  2  command: 0 VERI_YUKLE, 1 AGIRLIK_YUKLE, 2 CALISTIR, 3 SIFIRLA
- deger1_i  input  32  first load word; for CALISTIR, [3:0] = N-1
- deger2_i  input  32  second load word
- ikinci_gecerli_i  input  1  deger2_i is valid (two-word load)
- yaz1_deger_o  output  32  bank write word 1
- yaz2_deger_o  output  32  bank write word 2
- veri_yaz1_en_o, veri_yaz2_en_o  output  1 each  data bank write enables
- agirlik_yaz1_en_o, agirlik_yaz2_en_o  output  1 each  weight bank write enables
- veri_oku_en_o, agirlik_oku_en_o  output  1 each  bank read-pointer advance
- veri_deger_i, agirlik_deger_i  input  32 each  current bank read word (combinational from bank)
- obek_sifirla_o  output  1  synchronous clear to both banks
- sonuc_o  output  32  dot-product result
- sonuc_gecerli_o  output  1  result valid
- sonuc_hazir_i  input  1  result consumer ready
- hata_o  output  1  sticky error flag

Behaviour:
- Reset values: all outputs 0 except buyruk_hazir_o=1. State BOSTA, both fill counters 0, accumulator 0.
- States: BOSTA, HESAPLA, SONUC, TEMIZLE.
- buyruk_hazir_o=1 only in BOSTA. A command is accepted when valid and ready are both high.
- VERI_YUKLE / AGIRLIK_YUKLE:
  - Handled combinationally in the accept cycle: yaz1_deger_o=deger1_i, yaz2_deger_o=deger2_i.
  - Assert the bank's yaz1_en_o; also assert yaz2_en_o if ikinci_gecerli_i.
  - The bank's fill counter (0..16) increments by the number of words written. State stays BOSTA.
- Overflow: if fill is 16, no enable is asserted. If fill is 15 and two words are offered, only yaz1 is asserted. In both cases hata_o is set.
- CALISTIR:
  - N = deger1_i[3:0]+1.
  - If N > data fill or N > weight fill: hata_o is set, the accumulator is forced to 0, and the next state is SONUC (no bank reads).
  - Otherwise the accumulator is cleared, a cycle counter is loaded with N, and the next state is HESAPLA.
- HESAPLA (exactly N cycles):
  - Each cycle: acc <= acc + low32(signed(veri_deger_i) * signed(agirlik_deger_i)).
  - veri_oku_en_o and agirlik_oku_en_o are both asserted; the counter decrements.
  - On the last cycle, both fill counters decrease by N and the next state is SONUC.
- Latency: CALISTIR accepted in cycle T gives sonuc_gecerli_o=1 from cycle T+N+1.
- SONUC:
  - sonuc_gecerli_o=1 and sonuc_o=acc, held stable until sonuc_hazir_i=1.
  - Then BOSTA in the next cycle, with sonuc_gecerli_o dropping.
  - sonuc_hazir_i arriving in the first SONUC cycle is honoured.
- SIFIRLA:
  - Accept, then TEMIZLE for exactly one cycle: obek_sifirla_o=1, fill counters 0, accumulator 0, hata_o cleared.
  - Then BOSTA.
- Bank pointers wrap mod 16 inside the banks. The controller never issues a read beyond the fill count, so wrap is transparent.
- hata_o is sticky and is cleared only by rst_i or SIFIRLA.
- rst_i in any state, including mid-HESAPLA or mid-SONUC, returns to the reset values in the next cycle. The partial result is discarded and no result is emitted.

Optional Feature:
- Macro: YZ_DOYURMA_EN.
- Defined: the product is taken as full 64-bit signed and the accumulation saturates at 0x7FFFFFFF / 0x80000000. Once saturated, the value is held for the remainder of the run.
- Undefined: 32-bit two's-complement wrap-around as described above.

Test Plan:
- Load data {1,2,3} (one 2-word load + one 1-word load) and weights {4,5,6}, then CALISTIR deger1_i=2 -> sonuc_o=32 at T+4. Both fill counters end at 0.
- Data {-3,7}, weights {2,-1}, CALISTIR N=2 with sonuc_hazir_i held low 5 cycles -> sonuc_o=0xFFFFFFF3 (-13) held stable, then BOSTA the cycle after sonuc_hazir_i=1.
- 15 single-word data loads, then a 2-word load -> only veri_yaz1_en_o pulses, hata_o=1. Then CALISTIR N=16 with 0 weights -> sonuc_o=0 at T+1, no oku_en pulses.
- Run on data {0x40000000 x2}, weights {4,4} -> sonuc_o=0 with YZ_DOYURMA_EN undefined, 0x7FFFFFFF with it defined.
- SIFIRLA after the error case -> obek_sifirla_o single-cycle pulse, hata_o=0, buyruk_hazir_o low for that cycle.
- rst_i asserted on the 2nd cycle of an N=8 HESAPLA -> next cycle buyruk_hazir_o=1, all other outputs 0, sonuc_gecerli_o never asserted.
